// File: rtl/conv_pe_sequencer_if.sv
// Bundle of control, PE-array and status signals between the layer controller and conv_pe_sequencer.
// When CONV_SEQ_PERF_EN is defined, the bundle also carries perf_cycles/hold_cycles.
interface conv_pe_sequencer_if #(
   parameter int NUM_PE = 16,
   parameter int CNT_W  = 16
);
   // start is a one-cycle request, honoured only while busy is low.
   // valid is a per-lane level: a capture happens on every cycle where all enabled lanes are high.
   logic              start;
   logic              abort;
   logic              pause;
   logic [NUM_PE-1:0] pe_mask;
   logic [NUM_PE-1:0] valid;
   logic              cal_start;
   logic [NUM_PE-1:0] PE_reset;
   logic [NUM_PE-1:0] PE_finish;
   logic              ofm_wr_en;
   logic [CNT_W-1:0]  pixel_idx;
   logic [CNT_W-1:0]  ofm_cnt;
   logic              busy;
   logic              done;
   logic              timeout;
   logic [2:0]        state_dbg;
`ifdef CONV_SEQ_PERF_EN
   logic [31:0]       perf_cycles;
   logic [31:0]       hold_cycles;
`endif

   modport master (
`ifdef CONV_SEQ_PERF_EN
      input  perf_cycles, hold_cycles,
`endif
      output start, abort, pause, pe_mask, valid,
      input  cal_start, PE_reset, PE_finish, ofm_wr_en, pixel_idx, ofm_cnt,
      input  busy, done, timeout, state_dbg
   );

   modport slave (
`ifdef CONV_SEQ_PERF_EN
      output perf_cycles, hold_cycles,
`endif
      input  start, abort, pause, pe_mask, valid,
      output cal_start, PE_reset, PE_finish, ofm_wr_en, pixel_idx, ofm_cnt,
      output busy, done, timeout, state_dbg
   );
endinterface

// File: rtl/conv_pe_sequencer.sv
// Sequences PE_reset/PE_finish pulses per OFM pixel for one conv layer pass, counts captures, reports done/timeout.
// Optional macro CONV_SEQ_PERF_EN adds perf_cycles and hold_cycles counters.
module conv_pe_sequencer #(
   parameter int NUM_PE      = 16,
   parameter int START_DELAY = 2,
   parameter int ACC_CYCLES  = 34,
   parameter int NUM_PIXELS  = 3136,
   parameter int DRAIN_MAX   = 64,
   parameter int CNT_W       = 16
) (
   input logic              clk,
   input logic              reset,
   conv_pe_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_PREP, S_RST, S_ACC, S_FIN, S_HOLD, S_DRAIN, S_DONE
   } state_t;

   localparam int TMR_W = 32;

   state_t            state, nxt;
   logic [TMR_W-1:0]  tmr, tmr_nxt;
   logic [NUM_PE-1:0] mask;
   logic [CNT_W-1:0]  pix, pix_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              timeout_q, timeout_nxt;
   logic              accept, capture, last_pix;
   logic              cal_q, busy_q, done_q, wr_q;
   logic [NUM_PE-1:0] rst_q, fin_q;

   assign accept   = (state == S_IDLE) && bus.start;
   assign capture  = (state != S_IDLE) && !bus.abort && (mask != '0) && ((bus.valid & mask) == mask);
   assign last_pix = (pix == CNT_W'(NUM_PIXELS - 1));

   // tmr is loaded on entry to a timed state and counts down to 0 on its last cycle.
   // DRAIN loads DRAIN_MAX-2 so the timeout DONE lands DRAIN_MAX cycles after the final FIN.
   always_comb begin
      nxt         = state;
      tmr_nxt     = tmr;
      pix_nxt     = pix;
      cnt_nxt     = cnt;
      timeout_nxt = timeout_q;
      if (capture && (cnt != '1)) cnt_nxt = cnt + 1'b1;
      if (bus.abort && (state != S_IDLE)) begin
         nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (bus.start) begin
               nxt         = S_PREP;
               tmr_nxt     = TMR_W'(START_DELAY - 1);
               pix_nxt     = '0;
               cnt_nxt     = '0;
               timeout_nxt = 1'b0;
            end
            S_PREP: if (tmr == '0) nxt = S_RST; else tmr_nxt = tmr - 1'b1;
            S_RST: begin
               nxt     = S_ACC;
               tmr_nxt = TMR_W'(ACC_CYCLES - 1);
            end
            S_ACC: if (tmr == '0) nxt = S_FIN; else tmr_nxt = tmr - 1'b1;
            S_FIN: if (last_pix) begin
               nxt     = S_DRAIN;
               tmr_nxt = TMR_W'(DRAIN_MAX - 2);
            end else begin
               pix_nxt = pix + 1'b1;
               nxt     = bus.pause ? S_HOLD : S_RST;
            end
            S_HOLD: if (!bus.pause) nxt = S_RST;
            S_DRAIN: if (cnt_nxt == CNT_W'(NUM_PIXELS)) begin
               nxt = S_DONE;
            end else if (tmr == '0) begin
               nxt         = S_DONE;
               timeout_nxt = 1'b1;
            end else begin
               tmr_nxt = tmr - 1'b1;
            end
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the next state so every port is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         tmr       <= '0;
         mask      <= '0;
         pix       <= '0;
         cnt       <= '0;
         timeout_q <= 1'b0;
         cal_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wr_q      <= 1'b0;
         rst_q     <= '0;
         fin_q     <= '0;
      end else begin
         state     <= nxt;
         tmr       <= tmr_nxt;
         pix       <= pix_nxt;
         cnt       <= cnt_nxt;
         timeout_q <= timeout_nxt;
         if (accept) mask <= bus.pe_mask;
         cal_q     <= (nxt != S_IDLE) && (nxt != S_DONE);
         busy_q    <= (nxt != S_IDLE);
         done_q    <= (nxt == S_DONE);
         wr_q      <= capture;
         rst_q     <= (nxt == S_RST) ? mask : '0;
         fin_q     <= (nxt == S_FIN) ? mask : '0;
      end
   end

   assign bus.cal_start = cal_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.ofm_wr_en = wr_q;
   assign bus.PE_reset  = rst_q;
   assign bus.PE_finish = fin_q;
   assign bus.pixel_idx = pix;
   assign bus.ofm_cnt   = cnt;
   assign bus.timeout   = timeout_q;
   assign bus.state_dbg = state;

`ifdef CONV_SEQ_PERF_EN
   logic [31:0] perf_q, hold_q;

   // perf_q counts the accept cycle plus every non-IDLE cycle, so it freezes once DONE has passed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_q <= '0;
         hold_q <= '0;
      end else if (accept) begin
         perf_q <= 32'd1;
         hold_q <= '0;
      end else begin
         if (state != S_IDLE) perf_q <= perf_q + 1'b1;
         if (state == S_HOLD) hold_q <= hold_q + 1'b1;
      end
   end

   assign bus.perf_cycles = perf_q;
   assign bus.hold_cycles = hold_q;
`endif
endmodule

// File: tb/tb_conv_pe_sequencer.sv
// Bench for conv_pe_sequencer: table rows and random passes checked against a pixel-timing model.
module tb_conv_pe_sequencer;
   localparam int NUM_PE = 16;
   localparam int CNT_W  = 16;
   localparam int SD     = 2;
   localparam int ACC    = 34;
   localparam int NPIX   = 4;
   localparam int DMAX   = 64;

   typedef struct {
      logic [NUM_PE-1:0] mask;
      logic [NUM_PE-1:0] vpat;
      int                vd;
      int                pa;
      int                pl;
      int                restart;
      int                exp_cnt;
      bit                exp_to;
      int                exp_busy;
   } pass_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;

   conv_pe_sequencer_if #(.NUM_PE(NUM_PE), .CNT_W(CNT_W)) bus ();

   conv_pe_sequencer #(
      .NUM_PE(NUM_PE), .START_DELAY(SD), .ACC_CYCLES(ACC),
      .NUM_PIXELS(NPIX), .DRAIN_MAX(DMAX), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   // monitor: logs pulse cycles and values, sampled on the falling edge
   int                rst_cyc_q[$], fin_cyc_q[$], wr_cyc_q[$], done_cyc_q[$];
   logic [NUM_PE-1:0] rst_val_q[$], fin_val_q[$];
   int                busy_n, cal_n;

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.PE_reset != '0) begin
            rst_cyc_q.push_back(cyc);
            rst_val_q.push_back(bus.PE_reset);
         end
         if (bus.PE_finish != '0) begin
            fin_cyc_q.push_back(cyc);
            fin_val_q.push_back(bus.PE_finish);
         end
         if (bus.ofm_wr_en) wr_cyc_q.push_back(cyc);
         if (bus.done) done_cyc_q.push_back(cyc);
         if (bus.busy) busy_n++;
         if (bus.cal_start) cal_n++;
      end
   end

   // valid driver: answers each PE_finish with vpat, vdelay cycles later, for one cycle
   logic              auto_valid = 1'b0;
   logic [NUM_PE-1:0] vpat = '0;
   int                vdelay = 1;

   initial begin
      bus.valid = '0;
      forever begin
         @(negedge clk);
         if (auto_valid && !reset && (bus.PE_finish != '0)) begin
            repeat (vdelay) @(posedge clk);
            #1 bus.valid = vpat;
            @(posedge clk);
            #1 bus.valid = '0;
         end
      end
   end

   // driver / checking tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit pause_at(input int t, input int pa, input int pl);
      return (t >= pa) && (t < pa + pl);
   endfunction

   task automatic clear_logs();
      rst_cyc_q.delete(); fin_cyc_q.delete(); wr_cyc_q.delete(); done_cyc_q.delete();
      rst_val_q.delete(); fin_val_q.delete();
      busy_n = 0;
      cal_n  = 0;
   endtask

   // scoreboard: expected pulse offsets relative to the start cycle
   logic [31:0] exp_q[$];

   task automatic compare_cycles(input string name, ref int got_q[$], input int s);
      check({name, "_count"}, got_q.size(), exp_q.size());
      while (exp_q.size() > 0 && got_q.size() > 0)
         check({name, "_cycle"}, got_q.pop_front() - s, exp_q.pop_front());
      exp_q.delete();
   endtask

   task automatic run_pass(input pass_t v, input string tag);
      int s, t, h, hold_tot, done_off, f_last;
      int r[NPIX];
      int f[NPIX];
      clear_logs();
      // reference timing: pixel period ACC+2, HOLD from FIN+1 until the cycle pause is seen low
      t = SD + 1;
      hold_tot = 0;
      for (int p = 0; p < NPIX; p++) begin
         r[p] = t;
         f[p] = t + ACC + 1;
         if (p < NPIX - 1 && pause_at(f[p], v.pa, v.pl)) begin
            h = f[p] + 1;
            while (pause_at(h, v.pa, v.pl)) h++;
            hold_tot += h - f[p];
            t = h + 1;
         end else begin
            t = f[p] + 1;
         end
      end
      f_last   = f[NPIX-1];
      done_off = v.exp_to ? f_last + DMAX : f_last + v.vd + 1;

      bus.pe_mask = v.mask;
      vpat        = v.vpat;
      vdelay      = v.vd;
      auto_valid  = 1'b1;
      bus.start   = 1'b1;
      s = cyc;
      tick();
      bus.pe_mask = NUM_PE'($urandom);
      while (done_cyc_q.size() == 0 && (cyc - s) < 700) begin
         if (cyc - s == 1) check({tag, "_timeout_clr"}, bus.timeout, 0);
         bus.start = (cyc - s == v.restart);
         bus.pause = pause_at(cyc - s, v.pa, v.pl);
         tick();
      end
      bus.start = 1'b0;
      bus.pause = 1'b0;
      repeat (4) tick();

      if (v.mask != '0) for (int p = 0; p < NPIX; p++) exp_q.push_back(r[p]);
      compare_cycles({tag, "_rst"}, rst_cyc_q, s);
      if (v.mask != '0) for (int p = 0; p < NPIX; p++) exp_q.push_back(f[p]);
      compare_cycles({tag, "_fin"}, fin_cyc_q, s);
      if (v.exp_cnt != 0) for (int p = 0; p < NPIX; p++) exp_q.push_back(f[p] + v.vd + 1);
      compare_cycles({tag, "_wr"}, wr_cyc_q, s);
      while (rst_val_q.size() > 0) check({tag, "_rst_val"}, rst_val_q.pop_front(), v.mask);
      while (fin_val_q.size() > 0) check({tag, "_fin_val"}, fin_val_q.pop_front(), v.mask);
      check({tag, "_done_count"}, done_cyc_q.size(), 1);
      if (done_cyc_q.size() > 0) check({tag, "_done_cycle"}, done_cyc_q[0] - s, done_off);
      check({tag, "_timeout"}, bus.timeout, v.exp_to);
      check({tag, "_ofm_cnt"}, bus.ofm_cnt, v.exp_cnt);
      check({tag, "_pixel_idx"}, bus.pixel_idx, NPIX - 1);
      check({tag, "_busy_cycles"}, busy_n, done_off);
      check({tag, "_cal_cycles"}, cal_n, done_off - 1);
      check({tag, "_idle"}, bus.busy, 0);
      if (v.exp_busy != 0) check({tag, "_busy_total"}, busy_n, v.exp_busy);
`ifdef CONV_SEQ_PERF_EN
      check({tag, "_perf_cycles"}, bus.perf_cycles, done_off + 1);
      check({tag, "_hold_cycles"}, bus.hold_cycles, hold_tot);
`endif
   endtask

   pass_t tbl[6];
   pass_t rv;
   int    s0;

   initial begin
      // vector table: {mask, valid pattern, valid delay, pause at, pause len, restart, ofm_cnt, timeout, busy}
      tbl[0] = '{16'hFFFF, 16'hFFFF, 1, 0,  0,  50, NPIX, 1'b0, 148};
      tbl[1] = '{16'hFFFF, 16'hFFFF, 1, 70, 10, 0,  NPIX, 1'b0, 0};
      tbl[2] = '{16'hFFFF, 16'h0000, 1, 0,  0,  0,  0,    1'b1, 0};
      tbl[3] = '{16'h00FF, 16'h00FF, 2, 0,  0,  0,  NPIX, 1'b0, 0};
      tbl[4] = '{16'h00FF, 16'h007F, 1, 0,  0,  0,  0,    1'b1, 0};
      tbl[5] = '{16'h0000, 16'hFFFF, 1, 0,  0,  0,  0,    1'b1, 0};

      bus.start   = 1'b0;
      bus.abort   = 1'b0;
      bus.pause   = 1'b0;
      bus.pe_mask = '0;
      reset       = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_busy", bus.busy, 0);
      check("reset_cal_start", bus.cal_start, 0);
      check("reset_pulses", {bus.PE_reset, bus.PE_finish}, 0);
      check("reset_counters", {bus.pixel_idx, bus.ofm_cnt}, 0);
      check("reset_flags", {bus.done, bus.timeout, bus.ofm_wr_en}, 0);
      check("reset_state", bus.state_dbg, 0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) run_pass(tbl[i], $sformatf("tbl%0d", i));

      for (int i = 0; i < 8; i++) begin
         case ($urandom_range(0, 3))
            0:       rv.mask = '1;
            1:       rv.mask = '0;
            default: rv.mask = NUM_PE'($urandom) | NUM_PE'(1);
         endcase
         if ($urandom_range(0, 2) == 0) rv.vpat = rv.mask & (rv.mask - 1'b1);
         else rv.vpat = rv.mask | NUM_PE'($urandom);
         rv.vd       = $urandom_range(1, 8);
         rv.pa       = $urandom_range(4, 150);
         rv.pl       = $urandom_range(0, 20);
         rv.restart  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 140) : 0;
         rv.exp_cnt  = ((rv.mask != '0) && ((rv.vpat & rv.mask) == rv.mask)) ? NPIX : 0;
         rv.exp_to   = (rv.exp_cnt != NPIX);
         rv.exp_busy = 0;
         run_pass(rv, $sformatf("rnd%0d", i));
      end

      // abort during pixel 2 accumulate
      clear_logs();
      bus.pe_mask = '1;
      vpat        = '1;
      vdelay      = 1;
      bus.start   = 1'b1;
      s0 = cyc;
      tick();
      bus.start = 1'b0;
      while (cyc - s0 < 90) tick();
      check("abort_pre_pixel_idx", bus.pixel_idx, 2);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
      check("abort_busy", bus.busy, 0);
      check("abort_cal_start", bus.cal_start, 0);
      check("abort_pixel_idx", bus.pixel_idx, 2);
      check("abort_ofm_cnt", bus.ofm_cnt, 2);
      repeat (60) tick();
      check("abort_rst_count", rst_cyc_q.size(), 3);
      check("abort_fin_count", fin_cyc_q.size(), 2);
      check("abort_no_done", done_cyc_q.size(), 0);
      check("abort_still_idle", bus.busy, 0);

      // asynchronous reset while in PREP
      clear_logs();
      bus.pe_mask = '1;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      check("prep_cal_start", bus.cal_start, 1);
      #2 reset = 1'b1;
      #1;
      check("areset_cal_busy", {bus.cal_start, bus.busy}, 0);
      check("areset_pulses", {bus.PE_reset, bus.PE_finish, bus.ofm_wr_en}, 0);
      check("areset_counters", {bus.pixel_idx, bus.ofm_cnt}, 0);
      check("areset_flags", {bus.done, bus.timeout}, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      repeat (50) tick();
      check("areset_no_done", done_cyc_q.size(), 0);
      check("areset_no_pulses", rst_cyc_q.size(), 0);
      check("areset_idle", bus.busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
